ca_run_sequencer: RTL and testbench
===================================

# ca_run_sequencer

Run controller for the 1-D r=2 cellular-automaton entropy datapath. On a start request it drives the shared 3-bit `op` bus seen by every cell and subsequence counter: CA init, subsequence-counter init, a warm-up of plain iterations, then the measurement loop. Each measured iteration is an ITERATE followed by a TRACK, with one COUNT after every 4 measured iterations (h=4). It reports busy/done and progress, and returns the bus to a no-op when idle, aborted or reset.

## Interface
Parameters:
- `WARMUP`, 128, plain ITERATE cycles before measuring; range 0..65535.
- `N_ITERATIONS`, 4096, measured iterations; multiple of 4, range 4..4096.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level-sampled run request; honoured only in IDLE.
- `abort`  in  1  cancel the run; honoured in every state except IDLE.
- `op`  out  3  command bus: 0 CA_INIT, 1 CA_ITERATE, 2 SUBSEQ_COUNT, 3 SUBSEQ_INIT, 4 SUBSEQ_TRACK, 7 NOP; 5 and 6 are never driven.
- `busy`  out  1  high while a run is issuing commands.
- `done`  out  1  one-cycle pulse after a run completes normally.
- `meas_count`  out  13  measured iterations completed in the current or last run.

## Operation
- All outputs are registered. The datapath acts on the `op` value present at each rising edge, so each `op` value lasts exactly one cycle.
- States and the `op` value held in each:
  - IDLE: NOP.
  - INIT_CA: CA_INIT.
  - INIT_SS: SUBSEQ_INIT.
  - WARM: ITERATE.
  - M_ITER: ITERATE.
  - M_TRACK: TRACK.
  - M_COUNT: COUNT.
  - FIN: NOP.
- State transitions:
  - IDLE -> INIT_CA when `start`=1 and `abort`=0.
  - INIT_CA -> INIT_SS.
  - INIT_SS -> WARM, or -> M_ITER when `WARMUP`=0.
  - WARM stays for `WARMUP` cycles, then -> M_ITER.
  - M_ITER -> M_TRACK.
  - M_TRACK -> M_ITER while the group count is below 4.
  - M_TRACK -> M_COUNT when the 4th TRACK of the group is issued.
  - M_COUNT -> M_ITER if `meas_count` < `N_ITERATIONS`, else -> FIN.
  - FIN -> IDLE.
- Counters:
  - 16-bit warm-up counter.
  - 2-bit group counter: increments on each TRACK and wraps 3->0.
  - `meas_count`: increments on each TRACK, is cleared on entry to INIT_CA, and holds its value in IDLE. It reaches `N_ITERATIONS` with no wrap, since 4096 fits in 13 bits.
- `busy`=1 in INIT_CA through M_COUNT; 0 in IDLE and FIN.
- `done`=1 only in FIN.
- abort:
  - Next state is IDLE and `op`=NOP in the next cycle.
  - `done` is not pulsed.
  - `meas_count` holds the partial value.
  - An abort in FIN is ignored, so `done` still pulses.
- `start` while busy is ignored; a run is never restarted mid-flight.
- If `start` is held high, a new run begins in the cycle after FIN; the IDLE cycle between runs is kept.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - state IDLE, `op`=7, `busy`=0, `done`=0, `meas_count`=0.
  - The same values apply when reset is asserted mid-run; no partial command is issued after that edge.
- Latency: `start` sampled at edge k produces `op`=CA_INIT and `busy`=1 during cycle k+1.
- Run length: 2 + `WARMUP` + 2·`N_ITERATIONS` + `N_ITERATIONS`/4 busy cycles, followed by 1 FIN cycle.
  - Defaults: 2 + 128 + 8192 + 1024 = 9346 busy cycles, then `done`.
- The COUNT cycle immediately follows the 4th TRACK.
- The ITERATE of the next group immediately follows COUNT; there are no idle gaps inside a run.
- `meas_count` updates at the edge that ends a TRACK cycle, so it is visible during the following cycle.
- Cells latch neighbours on the falling edge. `op` must be stable from rising edge to rising edge, which registered outputs guarantee.

## Test plan
- Reset and idle: hold `rst_n`=0 for 3 cycles, then release with `start`=0 for 10 cycles -> `op`=7, `busy`=0, `done`=0, `meas_count`=0 throughout.
- Short run with `WARMUP`=2, `N_ITERATIONS`=8 and a 1-cycle `start` pulse:
  - Required `op` sequence: 0,3,1,1, 1,4,1,4,1,4,1,4, 2, 1,4,1,4,1,4,1,4, 2, 7.
  - `busy`=1 for exactly 22 cycles.
  - `done`=1 exactly in cycle 23.
  - `meas_count`=8 at the end.
- Default parameters:
  - Count busy cycles -> 9346.
  - Count ops issued -> exactly 4096 TRACK, 1024 COUNT and 4224 ITERATE.
  - `done` pulses once.
- `WARMUP`=0, `N_ITERATIONS`=4 -> ops 0,3,1,4,1,4,1,4,1,4,2,7; `busy`=11 cycles.
- Abort and restart:
  - Assert `abort` during the 3rd M_TRACK of the short run -> next cycle `op`=7, `busy`=0, no `done`, `meas_count`=3.
  - A subsequent `start` -> `op` sequence restarts at CA_INIT, `meas_count` clears.
- Corner events:
  - `start`+`abort` together in IDLE -> no run.
  - `start` held high during a run -> no restart mid-run; the next run begins 1 cycle after FIN.
  - `rst_n`=0 during WARM -> `op`=7 at the next edge.

Source files
------------

// File: rtl/ca_run_sequencer.sv
// rtl/ca_run_sequencer.sv - run controller driving the shared CA/subsequence op bus
module ca_run_sequencer #(
    parameter int unsigned WARMUP       = 128,
    parameter int unsigned N_ITERATIONS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic [12:0] meas_count
);

    localparam logic [2:0] OP_CA_INIT      = 3'd0;
    localparam logic [2:0] OP_CA_ITERATE   = 3'd1;
    localparam logic [2:0] OP_SUBSEQ_COUNT = 3'd2;
    localparam logic [2:0] OP_SUBSEQ_INIT  = 3'd3;
    localparam logic [2:0] OP_SUBSEQ_TRACK = 3'd4;
    localparam logic [2:0] OP_NOP          = 3'd7;

    localparam logic [15:0] WARM_LAST = 16'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [12:0] N_MEAS    = 13'(N_ITERATIONS);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_CA, S_INIT_SS, S_WARM, S_M_ITER, S_M_TRACK, S_M_COUNT, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] warm_q, warm_d;
    logic [1:0]  grp_q, grp_d;
    logic [12:0] meas_q, meas_d;
    logic [2:0]  op_q, op_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        grp_d   = grp_q;
        meas_d  = meas_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_INIT_CA;
                    meas_d  = 13'd0;
                    grp_d   = 2'd0;
                end
            end
            S_INIT_CA: state_d = S_INIT_SS;
            S_INIT_SS: begin
                warm_d  = 16'd0;
                state_d = (WARMUP == 0) ? S_M_ITER : S_WARM;
            end
            S_WARM: begin
                warm_d = warm_q + 16'd1;
                if (warm_q == WARM_LAST) begin
                    state_d = S_M_ITER;
                end
            end
            S_M_ITER: state_d = S_M_TRACK;
            S_M_TRACK: begin
                // The TRACK is already on the bus this cycle, so it counts even if aborted.
                grp_d   = grp_q + 2'd1;
                meas_d  = meas_q + 13'd1;
                state_d = (grp_q == 2'd3) ? S_M_COUNT : S_M_ITER;
            end
            S_M_COUNT: state_d = (meas_q < N_MEAS) ? S_M_ITER : S_FIN;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so they leave flops aligned with the state.
    always_comb begin
        op_d   = OP_NOP;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_INIT_CA: begin op_d = OP_CA_INIT;      busy_d = 1'b1; end
            S_INIT_SS: begin op_d = OP_SUBSEQ_INIT;  busy_d = 1'b1; end
            S_WARM:    begin op_d = OP_CA_ITERATE;   busy_d = 1'b1; end
            S_M_ITER:  begin op_d = OP_CA_ITERATE;   busy_d = 1'b1; end
            S_M_TRACK: begin op_d = OP_SUBSEQ_TRACK; busy_d = 1'b1; end
            S_M_COUNT: begin op_d = OP_SUBSEQ_COUNT; busy_d = 1'b1; end
            S_FIN:     done_d = 1'b1;
            default:   op_d = OP_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            warm_q  <= 16'd0;
            grp_q   <= 2'd0;
            meas_q  <= 13'd0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            grp_q   <= grp_d;
            meas_q  <= meas_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign op         = op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign meas_count = meas_q;

endmodule

// File: tb/tb_ca_run_sequencer.sv
// tb/tb_ca_run_sequencer.sv - directed table-driven bench for ca_run_sequencer
module tb_ca_run_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic start_c = 1'b0, abort_c = 1'b0;
    logic [2:0]  op_a, op_b, op_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [12:0] meas_a, meas_b, meas_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ca_run_sequencer #(.WARMUP(2), .N_ITERATIONS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .op(op_a), .busy(busy_a), .done(done_a), .meas_count(meas_a));

    ca_run_sequencer dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .op(op_b), .busy(busy_b), .done(done_b), .meas_count(meas_b));

    ca_run_sequencer #(.WARMUP(0), .N_ITERATIONS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
        .op(op_c), .busy(busy_c), .done(done_c), .meas_count(meas_c));

    typedef struct {
        int dut;
        bit start;
        bit abort;
        int op;
        int busy;
        int done;
        int meas;
    } vec_t;

    vec_t vecs[$];
    int sr_op[24];
    int sr_m[24];
    int w0_op[13];
    int w0_m[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int d, input bit s, input bit a,
                                input int o, input int b, input int dn, input int m);
        vec_t v;
        v.dut = d; v.start = s; v.abort = a;
        v.op = o; v.busy = b; v.done = dn; v.meas = m;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int d, input bit s, input bit a);
        start_a = (d == 0) ? s : 1'b0;  abort_a = (d == 0) ? a : 1'b0;
        start_c = (d == 2) ? s : 1'b0;  abort_c = (d == 2) ? a : 1'b0;
    endtask

    initial begin
        int n_busy, n_iter, n_track, n_count, n_done;
        sr_op = '{0,3,1,1, 1,4,1,4,1,4,1,4, 2, 1,4,1,4,1,4,1,4, 2, 7,7};
        sr_m  = '{0,0,0,0, 0,0,1,1,2,2,3,3, 4, 4,4,5,5,6,6,7,7, 8, 8,8};
        w0_op = '{0,3,1,4,1,4,1,4,1,4,2,7,7};
        w0_m  = '{0,0,0,0,1,1,2,2,3,3,4,4,4};

        // Short run, one-cycle start pulse: row i expects cycle i+1.
        for (int i = 0; i < 24; i++)
            add(0, i == 0, 1'b0, sr_op[i], int'(i < 22), int'(i == 22), sr_m[i]);
        // Abort in the 3rd TRACK, then restart and abort early.
        for (int i = 0; i < 10; i++)
            add(0, i == 0, 1'b0, sr_op[i], 1, 0, sr_m[i]);
        add(0, 1'b0, 1'b1, 7, 0, 0, 3);
        add(0, 1'b0, 1'b0, 7, 0, 0, 3);
        add(0, 1'b1, 1'b0, 0, 1, 0, 0);
        add(0, 1'b0, 1'b0, 3, 1, 0, 0);
        add(0, 1'b0, 1'b1, 7, 0, 0, 0);
        // start with abort in IDLE must not launch.
        add(0, 1'b1, 1'b1, 7, 0, 0, 0);
        add(0, 1'b0, 1'b0, 7, 0, 0, 0);
        // WARMUP=0, N=4 single run.
        for (int i = 0; i < 13; i++)
            add(2, i == 0, 1'b0, w0_op[i], int'(i < 11), int'(i == 11), w0_m[i]);
        // Same with start held: one IDLE cycle then the next run.
        for (int i = 0; i < 13; i++)
            add(2, 1'b1, 1'b0, w0_op[i], int'(i < 11), int'(i == 11), w0_m[i]);
        add(2, 1'b1, 1'b0, 0, 1, 0, 0);
        add(2, 1'b0, 1'b1, 7, 0, 0, 0);

        // Reset held 3 cycles, then idle for 10.
        rst_n = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("reset_idle[%0d]", i), int'({op_a, busy_a, done_a, meas_a}),
                int'({3'd7, 1'b0, 1'b0, 13'd0}));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            int ao, ab, ad, am;
            drive(vecs[i].dut, vecs[i].start, vecs[i].abort);
            @(posedge clk); #1;
            if (vecs[i].dut == 0) begin
                ao = int'(op_a); ab = int'(busy_a); ad = int'(done_a); am = int'(meas_a);
            end else begin
                ao = int'(op_c); ab = int'(busy_c); ad = int'(done_c); am = int'(meas_c);
            end
            chk($sformatf("vec%0d_op", i), ao, vecs[i].op);
            chk($sformatf("vec%0d_busy", i), ab, vecs[i].busy);
            chk($sformatf("vec%0d_done", i), ad, vecs[i].done);
            chk($sformatf("vec%0d_meas", i), am, vecs[i].meas);
        end
        drive(0, 1'b0, 1'b0);

        // Reset asserted during WARM.
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("warm_op_before_reset", int'(op_a), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("warm_reset", int'({op_a, busy_a, done_a, meas_a}), int'({3'd7, 1'b0, 1'b0, 13'd0}));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_warm_reset_op", int'(op_a), 7);

        // Default parameters: full-length run with op tallies.
        n_busy = 0; n_iter = 0; n_track = 0; n_count = 0; n_done = 0;
        start_b = 1'b1;
        for (int c = 0; c < 9360; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (busy_b) n_busy++;
            if (done_b) n_done++;
            if (op_b == 3'd1) n_iter++;
            if (op_b == 3'd4) n_track++;
            if (op_b == 3'd2) n_count++;
        end
        chk("default_busy_cycles", n_busy, 9346);
        chk("default_iterate", n_iter, 4224);
        chk("default_track", n_track, 4096);
        chk("default_count", n_count, 1024);
        chk("default_done_pulses", n_done, 1);
        chk("default_meas", int'(meas_b), 4096);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
